// File: rtl/cdb_pkg.sv
// Shared definitions for the Common Data Bus write-back path: bus widths,
// producer indices, opcode encodings and the {tag, data} entry that every
// producer hands to the arbiter.
package cdb_pkg;

    // Bus geometry shared by the producers, the arbiter and the snoopers.
    localparam int NUM_SRC = 3;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 3;
    localparam int DEPTH   = 2;

    // Width of the granted-source index on the bus.
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Width of one buffered result.
    localparam int ENTRY_W = TAG_W + DATA_W;

    // Producer indices: which functional unit drives which arbiter input.
    localparam int SRC_ADD = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_LD  = 2;

    // Opcode encodings used by the issue logic feeding these units.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_SD  = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;

    // One finished result: destination register tag plus its value.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    // Round-robin successor of a source index, wrapping at NUM_SRC.
    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx);
        logic [SRC_W-1:0] nxt;
        if (idx == SRC_W'(NUM_SRC - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + SRC_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result buffer: a small power-of-two FIFO with an occupancy
// count, a synchronous flush that empties it, and a head that is always
// visible so the arbiter can look at it before deciding to pop.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    cdb_entry_t       mem_q [DEPTH];

    // Pointer and count update; a flush beats any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= cdb_entry_t'(wdata_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers finished results from each functional unit
// and broadcasts exactly one of them per cycle, round-robin, on a registered
// valid/tag/data/source bus snooped by the register file and the stations.
// Optional macro CDB_BYPASS_EN lets a result arriving at an empty buffer
// compete for the bus in the same cycle and skip the buffer when it wins.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DEPTH = cdb_pkg::DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    output logic                      cdb_valid_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic [DATA_W-1:0]         cdb_data_o,
    output logic [SRC_W-1:0]          cdb_src_o
);

    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_push;
    logic [NUM_SRC-1:0] fifo_pop;
    logic [NUM_SRC-1:0] src_live;
    logic [NUM_SRC-1:0] head_valid;
    logic [NUM_SRC-1:0] head_bypass;
    logic [ENTRY_W-1:0] src_entry  [NUM_SRC];
    logic [ENTRY_W-1:0] fifo_rdata [NUM_SRC];
    cdb_entry_t         head_entry [NUM_SRC];

    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    cdb_entry_t         grant_entry;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    // One buffer per producer; tag 0 means "no destination" and is never stored.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_entry[i]   = {src_tag_i[i*TAG_W +: TAG_W], src_data_i[i*DATA_W +: DATA_W]};
        assign src_live[i]    = src_valid_i[i] && (src_tag_i[i*TAG_W +: TAG_W] != '0);
        assign src_ready_o[i] = !fifo_full[i];

        cdb_src_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (fifo_push[i]),
            .pop_i   (fifo_pop[i]),
            .wdata_i (src_entry[i]),
            .rdata_o (fifo_rdata[i]),
            .empty_o (fifo_empty[i]),
            .full_o  (fifo_full[i])
        );
    end

    // Candidate head per source: the buffered head, or the live input when bypass is built in.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef CDB_BYPASS_EN
            head_bypass[i] = fifo_empty[i] && src_live[i];
`else
            head_bypass[i] = 1'b0;
`endif
            head_valid[i] = !fifo_empty[i] || head_bypass[i];
            head_entry[i] = head_bypass[i] ? cdb_entry_t'(src_entry[i]) : cdb_entry_t'(fifo_rdata[i]);
        end
    end

    // Round-robin search starting at rr_ptr; the first source with a head wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            cand = (int'(rr_ptr_q) + off) % NUM_SRC;
            if (!grant_valid && head_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(cand);
                grant_entry = head_entry[cand];
            end
        end
    end

    // Buffer control: pop the granted buffered head, push live results unless they bypassed.
    always_comb begin
        fifo_push = '0;
        fifo_pop  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!flush_i) begin
                fifo_pop[i]  = grant_valid && (grant_idx == SRC_W'(i)) && !fifo_empty[i];
                fifo_push[i] = src_live[i] && !fifo_full[i]
                               && !(grant_valid && (grant_idx == SRC_W'(i)) && head_bypass[i]);
            end
        end
    end

    // Next broadcast and pointer: a grant loads the bus, otherwise payload holds and valid drops.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (grant_valid && !flush_i) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = grant_entry.tag;
            cdb_data_d  = grant_entry.data;
            cdb_src_d   = grant_idx;
            rr_ptr_d    = rr_next(grant_idx);
        end
    end

    // Registered bus and round-robin pointer, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter in its default build (buffered path only):
// a table of single-cycle vectors followed by hand-written multi-cycle
// sequences for backpressure, flush and asynchronous reset.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic [2:0]  srcValid;
    logic [2:0]  srcReady;
    logic [8:0]  srcTag;
    logic [47:0] srcData;
    logic        cdbValid;
    logic [2:0]  cdbTag;
    logic [15:0] cdbData;
    logic [1:0]  cdbSrc;

    int checks = 0;
    int passes = 0;

    // One cycle of stimulus and the bus state expected just after its edge.
    typedef struct packed {
        logic [2:0]  valid;
        logic [8:0]  tags;
        logic [47:0] data;
        logic        flush;
        logic        expValid;
        logic [2:0]  expTag;
        logic [15:0] expData;
        logic [1:0]  expSrc;
        logic [2:0]  expReady;
    } vec_t;

    vec_t vecs [12];

    cdb_arbiter #(
        .DEPTH (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .flush_i     (flush),
        .src_valid_i (srcValid),
        .src_ready_o (srcReady),
        .src_tag_i   (srcTag),
        .src_data_i  (srcData),
        .cdb_valid_o (cdbValid),
        .cdb_tag_o   (cdbTag),
        .cdb_data_o  (cdbData),
        .cdb_src_o   (cdbSrc)
    );

    always #5 clk = ~clk;

    // Hard stop in case a sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [2:0] v, input logic [8:0] t, input logic [47:0] d,
                                   input logic f, input logic ev, input logic [2:0] et,
                                   input logic [15:0] ed, input logic [1:0] es, input logic [2:0] er);
        vec_t r;
        r.valid = v; r.tags = t; r.data = d; r.flush = f;
        r.expValid = ev; r.expTag = et; r.expData = ed; r.expSrc = es; r.expReady = er;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkCdb(input string name, input logic v, input logic [2:0] t,
                            input logic [15:0] d, input logic [1:0] s);
        checkOutput({name, " valid"}, 48'(cdbValid), 48'(v));
        checkOutput({name, " tag"},   48'(cdbTag),   48'(t));
        checkOutput({name, " data"},  48'(cdbData),  48'(d));
        checkOutput({name, " src"},   48'(cdbSrc),   48'(s));
    endtask

    // Drive one cycle of inputs, then return 1 ns after the rising edge.
    task automatic applyStimulus(input logic [2:0] v, input logic [8:0] t, input logic [47:0] d,
                                 input logic f);
        srcValid = v;
        srcTag   = t;
        srcData  = d;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] xData [4];
    logic [2:0]  seqTag [8];
    logic [15:0] seqData [8];
    logic [1:0]  seqSrc [8];

    initial begin
        int k;
        logic readyBefore;
        logic [2:0]  v;
        logic [8:0]  t;
        logic [47:0] d;

        rstN = 1'b1; flush = 1'b0; srcValid = '0; srcTag = '0; srcData = '0;

        // Asynchronous reset from time 0, released between edges.
        #1 rstN = 1'b0;
        #1;
        checkCdb("reset", 1'b0, 3'd0, 16'h0000, 2'd0);
        #10 rstN = 1'b1;
        #1;
        checkOutput("reset ready", 48'(srcReady), 48'(3'b111));

        vecs[0]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 0, 3'd0, 16'h0000, 2'd0, 3'b111);
        vecs[1]  = mkVec(3'b010, 9'o030, 48'h0000_00A5_0000, 0, 0, 3'd0, 16'h0000, 2'd0, 3'b111);
        vecs[2]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 1, 3'd3, 16'h00A5, 2'd1, 3'b111);
        vecs[3]  = mkVec(3'b100, 9'o500, 48'h0055_0000_0000, 0, 0, 3'd3, 16'h00A5, 2'd1, 3'b111);
        vecs[4]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 1, 3'd5, 16'h0055, 2'd2, 3'b111);
        vecs[5]  = mkVec(3'b111, 9'o421, 48'h0044_0022_0011, 0, 0, 3'd5, 16'h0055, 2'd2, 3'b111);
        vecs[6]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 1, 3'd1, 16'h0011, 2'd0, 3'b111);
        vecs[7]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 1, 3'd2, 16'h0022, 2'd1, 3'b111);
        vecs[8]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 1, 3'd4, 16'h0044, 2'd2, 3'b111);
        vecs[9]  = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 0, 3'd4, 16'h0044, 2'd2, 3'b111);
        vecs[10] = mkVec(3'b001, 9'o000, 48'h0000_0000_1234, 0, 0, 3'd4, 16'h0044, 2'd2, 3'b111);
        vecs[11] = mkVec(3'b000, 9'o000, 48'h0000_0000_0000, 0, 0, 3'd4, 16'h0044, 2'd2, 3'b111);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].tags, vecs[i].data, vecs[i].flush);
            checkCdb($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expTag, vecs[i].expData, vecs[i].expSrc);
            checkOutput($sformatf("vec%0d ready", i), 48'(srcReady), 48'(vecs[i].expReady));
        end

        // Backpressure: src 2 offers four results while src 0/1 keep the bus busy.
        xData = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
        seqTag  = '{3'd1, 3'd2, 3'd6, 3'd1, 3'd2, 3'd6, 3'd6, 3'd6};
        seqData = '{16'h0A01, 16'h0B01, 16'h0C01, 16'h0A02, 16'h0B02, 16'h0C02, 16'h0C03, 16'h0C04};
        seqSrc  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
        k = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            v = 3'b000; t = 9'o000; d = '0;
            if (cyc <= 2) begin
                v[1:0]   = 2'b11;
                t[5:0]   = 6'o21;
                d[15:0]  = (cyc == 1) ? 16'h0A01 : 16'h0A02;
                d[31:16] = (cyc == 1) ? 16'h0B01 : 16'h0B02;
            end
            if (k < 4) begin
                v[2]     = 1'b1;
                t[8:6]   = 3'd6;
                d[47:32] = xData[k];
            end
            readyBefore = srcReady[2];
            applyStimulus(v, t, d, 1'b0);
            if (v[2] && readyBefore) k++;
            if (cyc == 2) checkOutput("bp ready2 after two accepts", 48'(srcReady[2]), 48'(1'b0));
            if (cyc >= 2 && cyc <= 9) begin
                checkCdb($sformatf("bp grant%0d", cyc - 2), 1'b1, seqTag[cyc-2], seqData[cyc-2], seqSrc[cyc-2]);
            end
            if (cyc == 10) checkOutput("bp idle valid", 48'(cdbValid), 48'(1'b0));
        end
        checkOutput("bp accepted count", 48'(k), 48'(4));

        // Flush with a simultaneous push; rr_ptr (now 1) must survive the flush.
        applyStimulus(3'b111, 9'o421, 48'h0404_0202_0101, 1'b0);
        checkOutput("fl fill valid", 48'(cdbValid), 48'(1'b0));
        applyStimulus(3'b111, 9'o421, 48'h0444_0222_0111, 1'b0);
        checkCdb("fl first grant", 1'b1, 3'd1, 16'h0101, 2'd0);
        applyStimulus(3'b001, 9'o007, 48'h0000_0000_0BAD, 1'b1);
        checkOutput("fl valid", 48'(cdbValid), 48'(1'b0));
        checkOutput("fl ready", 48'(srcReady), 48'(3'b111));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 9'o000, 48'h0, 1'b0);
            checkOutput($sformatf("fl drained%0d", i), 48'(cdbValid), 48'(1'b0));
        end
        applyStimulus(3'b101, 9'o401, 48'h0F02_0000_0F00, 1'b0);
        checkOutput("fl repush valid", 48'(cdbValid), 48'(1'b0));
        applyStimulus(3'b000, 9'o000, 48'h0, 1'b0);
        checkCdb("fl rr kept", 1'b1, 3'd4, 16'h0F02, 2'd2);
        applyStimulus(3'b000, 9'o000, 48'h0, 1'b0);
        checkCdb("fl rr next", 1'b1, 3'd1, 16'h0F00, 2'd0);
        applyStimulus(3'b000, 9'o000, 48'h0, 1'b0);
        checkOutput("fl tail idle", 48'(cdbValid), 48'(1'b0));

        // Asynchronous reset in the middle of a burst (rr_ptr is 1 here).
        applyStimulus(3'b111, 9'o421, 48'h0D04_0D02_0D01, 1'b0);
        applyStimulus(3'b000, 9'o000, 48'h0, 1'b0);
        checkCdb("rst burst", 1'b1, 3'd2, 16'h0D02, 2'd1);
        #3 rstN = 1'b0;
        #1;
        checkCdb("rst async", 1'b0, 3'd0, 16'h0000, 2'd0);
        #2 rstN = 1'b1;
        #1;
        checkOutput("rst ready", 48'(srcReady), 48'(3'b111));
        applyStimulus(3'b111, 9'o421, 48'h0E04_0E02_0E01, 1'b0);
        checkOutput("rst lost", 48'(cdbValid), 48'(1'b0));
        applyStimulus(3'b000, 9'o000, 48'h0, 1'b0);
        checkCdb("rst first grant", 1'b1, 3'd1, 16'h0E01, 2'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits between the functional units (adder/sub RS, multiplier, load unit) and the Common Data Bus write-back into the FP register file.
- Each unit hands over its finished result (destination tag + value) and the block buffers it per source.
- It grants exactly one result per cycle, round-robin, and drives a registered CDB broadcast (valid/tag/data) that the register file and reservation stations snoop.
- Replaces the single-producer "posedge done" write-back with a multi-producer, one-write-per-cycle bus.

Parameters:
- NUM_SRC, 3, number of producing units (index 0 = add/sub, 1 = mul, 2 = load).
- DATA_W, 16, result width.
- TAG_W, 3, destination register index width (R1..R7; tag 0 is never broadcast).
- DEPTH, 2, entries in each per-source result buffer (power of two, ≥2).

Ports:
- clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous, active-high; discard all buffered results (branch squash).
- src_valid  in  NUM_SRC  per-source result-present strobe.
- src_ready  out  NUM_SRC  per-source buffer-not-full.
- src_tag  in  NUM_SRC*TAG_W  packed destination tags; source i at [i*TAG_W +: TAG_W].
- src_data  in  NUM_SRC*DATA_W  packed results; source i at [i*DATA_W +: DATA_W].
- cdb_valid  out  1  broadcast valid (register write enable).
- cdb_tag  out  TAG_W  broadcast destination register.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  $clog2(NUM_SRC)  index of the granted source.

Behaviour:
- Reset (Reset=0, asynchronous): all buffers empty; rr_ptr=0; cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0; src_ready all 1 once Reset deasserts.
- Push: on an edge with src_valid[i]&&src_ready[i], write {tag,data} at the tail of buffer i. src_ready[i] = (count[i] != DEPTH), decoded from registered count only, with no same-cycle pop look-ahead.
- src_valid with tag==0 is accepted and silently dropped; it is never buffered.
- Arbitration: combinational over non-empty buffer heads. Search starts at rr_ptr, ascending and wrapping mod NUM_SRC; the first non-empty source wins.
- On a grant to source k:
  - pop head k;
  - next edge: cdb_valid=1, cdb_tag/data = head k, cdb_src=k;
  - rr_ptr <= (k+1) mod NUM_SRC.
- No grant: cdb_valid=0; cdb_tag/data/src hold their previous values; rr_ptr unchanged.
- Latency: a result pushed at edge N appears on the CDB no earlier than edge N+1, i.e. 2 cycles from src_valid sampling to cdb_valid high.
- Push and pop on the same buffer in the same cycle (not full): count unchanged; FIFO order preserved. Pointers wrap mod DEPTH.
- The CDB has no backpressure: one broadcast per cycle, always consumed.
- Fairness: with all sources continuously non-empty, grants rotate 0,1,2,0,... and no source waits more than NUM_SRC-1 grants.
- flush=1 at an edge:
  - all counts/pointers cleared; same-edge pushes dropped; cdb_valid<=0; rr_ptr retained;
  - flush wins over any simultaneous push/pop.
- Reset mid-operation: buffered results lost; outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined:
  - if buffer i is empty and src_valid[i] is high, the incoming result competes in this cycle's arbitration as source i's head;
  - if it wins, it goes straight to the CDB register at the same edge (1-cycle latency) and is not written into the buffer;
  - if it loses, it is buffered normally; rr_ptr rules are unchanged.
- Undefined: every result passes through the buffer (2-cycle minimum latency), as above.

Decomposition:
- Shared package cdb_pkg:
  - DATA_W, TAG_W, NUM_SRC;
  - source index constants SRC_ADD=0, SRC_MUL=1, SRC_LD=2;
  - opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_LD=4'b0010, OP_SD=4'b0011, OP_MUL=4'b0100;
  - a packed cdb_entry_t {tag, data}.
- Sub-module cdb_src_fifo (one DEPTH-entry FIFO with count, push/pop/flush), instantiated NUM_SRC times. The arbiter and rr_ptr stay in the top.

Test Plan:
- Reset then idle → cdb_valid=0, src_ready=3'b111; a single push on src 1 (tag 3, data 16'h00A5) → next-but-one cycle cdb_valid=1, tag 3, data 00A5, cdb_src=1 (with CDB_BYPASS_EN: the very next edge).
- Push on all 3 sources in one cycle (tags 1,2,4; data 11,22,44) → three consecutive broadcasts in order src 0,1,2; rr_ptr ends at 0.
- Hold src 2 valid for 4 cycles while src 0/1 stay busy → src_ready[2] drops after 2 accepts; no entry is lost; all 4 values are broadcast in push order.
- Fill all buffers, then assert flush with a simultaneous push → next cycle cdb_valid=0, all counts 0, and the pushed value never appears.
- Assert Reset low mid-burst, asynchronously between edges → cdb_valid falls immediately; after release, src_ready=all 1 and the first grant goes to src 0.
- Push with tag 0 → no broadcast ever occurs; buffer count stays 0.
